// File: rtl/mem_access_ctrl_if.sv
// Data-bus handshake between the MEM-stage load/store controller and memory.
// The controller drives the request side (master); memory answers with ack/rdata.
interface mem_access_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_err;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_err,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_err,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: one bus handshake per access, raw load word
// registered for the extension stage, pipeline stalled while the bus is busy.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid,
    input  logic              mem_we,
    input  logic              isByte,
    input  logic              isHalf,
    input  logic              exsign,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic              flush,
    output logic              stall,
    output logic              misalign,
    mem_access_ctrl_if.master bus,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    output logic [1:0]        rd_low_addr,
    output logic              rd_isByte,
    output logic              rd_isHalf,
    output logic              rd_exsign
);
    // state | meaning
    // IDLE  | no access in flight; a clean MEM access launches the request
    // WAIT  | bus_req held stable until ack or timeout
    // DONE  | result cycle; pipeline advances, rd_valid for loads
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic        req_q, req_d, we_q, we_d, err_q, err_d, rdv_q, rdv_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rd_data_q, rd_data_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  lat_low_q, lat_low_d, rd_low_q, rd_low_d;
    logic        lat_byte_q, lat_byte_d, lat_half_q, lat_half_d, lat_sign_q, lat_sign_d;
    logic        rd_byte_q, rd_byte_d, rd_half_q, rd_half_d, rd_sign_q, rd_sign_d;
    logic [15:0] cnt_q, cnt_d;
    logic        killed_q, killed_d;
    logic        start, kill_now;

    always_comb begin
        misalign = mem_valid & (isByte ? 1'b0 : isHalf ? addr[0] : (addr[1:0] != 2'b00));
        start    = mem_valid & ~misalign & ~flush;
        stall    = 1'b0;
        kill_now = 1'b0;
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        err_d    = 1'b0;
        rdv_d    = 1'b0;
        rd_data_d  = rd_data_q;
        rd_low_d   = rd_low_q;
        rd_byte_d  = rd_byte_q;
        rd_half_d  = rd_half_q;
        rd_sign_d  = rd_sign_q;
        lat_low_d  = lat_low_q;
        lat_byte_d = lat_byte_q;
        lat_half_d = lat_half_q;
        lat_sign_d = lat_sign_q;
        cnt_d      = cnt_q;
        killed_d   = killed_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    stall      = 1'b1;
                    state_d    = WAIT;
                    req_d      = 1'b1;
                    we_d       = mem_we;
                    addr_d     = {addr[31:2], 2'b00};
                    lat_low_d  = addr[1:0];
                    lat_byte_d = isByte;
                    lat_half_d = isHalf;
                    lat_sign_d = exsign;
                    cnt_d      = 16'd0;
                    killed_d   = 1'b0;
                    if (!mem_we) begin
                        be_d    = 4'b1111;
                        wdata_d = 32'd0;
                    end else if (isByte) begin
                        be_d    = 4'b0001 << addr[1:0];
                        wdata_d = {4{wdata[7:0]}};
                    end else if (isHalf) begin
                        be_d    = addr[1] ? 4'b1100 : 4'b0011;
                        wdata_d = {2{wdata[15:0]}};
                    end else begin
                        be_d    = 4'b1111;
                        wdata_d = wdata;
                    end
                end
            end
            WAIT: begin
                stall    = 1'b1;
                kill_now = killed_q | flush;
                killed_d = kill_now;
                cnt_d    = cnt_q + 16'd1;
                // ack takes priority over a simultaneous timeout
                if (bus.bus_ack) begin
                    req_d    = 1'b0;
                    killed_d = 1'b0;
                    if (kill_now) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                        if (!we_q) begin
                            rdv_d     = 1'b1;
                            rd_data_d = bus.bus_rdata;
                            rd_low_d  = lat_low_q;
                            rd_byte_d = lat_byte_q;
                            rd_half_d = lat_half_q;
                            rd_sign_d = lat_sign_q;
                        end
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_d    = 1'b0;
                    err_d    = 1'b1;
                    killed_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
            rdv_q      <= 1'b0;
            rd_data_q  <= 32'd0;
            rd_low_q   <= 2'd0;
            rd_byte_q  <= 1'b0;
            rd_half_q  <= 1'b0;
            rd_sign_q  <= 1'b0;
            lat_low_q  <= 2'd0;
            lat_byte_q <= 1'b0;
            lat_half_q <= 1'b0;
            lat_sign_q <= 1'b0;
            cnt_q      <= 16'd0;
            killed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdv_q      <= rdv_d;
            rd_data_q  <= rd_data_d;
            rd_low_q   <= rd_low_d;
            rd_byte_q  <= rd_byte_d;
            rd_half_q  <= rd_half_d;
            rd_sign_q  <= rd_sign_d;
            lat_low_q  <= lat_low_d;
            lat_byte_q <= lat_byte_d;
            lat_half_q <= lat_half_d;
            lat_sign_q <= lat_sign_d;
            cnt_q      <= cnt_d;
            killed_q   <= killed_d;
        end
    end

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_err   = err_q;
    assign rd_valid      = rdv_q;
    assign rd_data       = rd_data_q;
    assign rd_low_addr   = rd_low_q;
    assign rd_isByte     = rd_byte_q;
    assign rd_isHalf     = rd_half_q;
    assign rd_exsign     = rd_sign_q;
endmodule
